du_job_scheduler: RTL and testbench

//  Shares one DU datapath (x/y/z registers, ldx/ldy/p/q/r controls) between two requesters.

---
 rtl/du_job_scheduler.sv | 146 ++++++++++++++
 tb/tb_du_job_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/du_job_scheduler.sv
// Two-requester job scheduler for the shared DU datapath.
// Arbitrates, latches operands, runs the 4-step DU program, returns x.
module du_job_scheduler #(
   parameter int XW    = 4,
   parameter int RW    = 8,
   parameter int RR_EN = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      req_valid,
   input  logic [2*XW-1:0] req_x,
   input  logic [2*XW-1:0] req_y,
   output logic [1:0]      req_ready,
   output logic            du_ldx,
   output logic            du_ldy,
   output logic            du_ldz,
   output logic            du_p,
   output logic            du_q,
   output logic            du_r,
   output logic [XW-1:0]   du_xin,
   output logic [XW-1:0]   du_yin,
   input  logic [RW-1:0]   du_x,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [RW-1:0]   res_data,
   output logic            res_id,
   output logic            res_err,
   output logic            busy,
   output logic [7:0]      jobs_done
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      YDIV3,
      YDIVZ,
      XUPD,
      RESP
   } state_t;

   state_t state, state_nxt;

   logic [XW-1:0] op_x, op_y;
   logic [XW-1:0] sel_x, sel_y;
   logic last_grant;
   logic win;
   logic take;

   // Round-robin favours the requester that did not win last time.
   always_comb begin
      win = 1'b0;
      unique case (req_valid)
         2'b01:   win = 1'b0;
         2'b10:   win = 1'b1;
         2'b11:   win = (RR_EN != 0) ? ~last_grant : 1'b0;
         default: win = 1'b0;
      endcase
   end

   assign sel_x = win ? req_x[2*XW-1:XW] : req_x[XW-1:0];
   assign sel_y = win ? req_y[2*XW-1:XW] : req_y[XW-1:0];
   assign take  = (state == IDLE) && (|req_valid);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (|req_valid) state_nxt = LOAD;
         LOAD:    state_nxt = YDIV3;
         YDIV3:   state_nxt = YDIVZ;
         YDIVZ:   state_nxt = XUPD;
         XUPD:    state_nxt = RESP;
         RESP:    if (res_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready = 2'b00;
      du_ldx    = 1'b0;
      du_ldy    = 1'b0;
      du_ldz    = 1'b0;
      du_p      = 1'b0;
      du_q      = 1'b0;
      du_r      = 1'b0;
      res_valid = 1'b0;
      busy      = 1'b1;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
            if (|req_valid) req_ready = win ? 2'b10 : 2'b01;
         end
         LOAD: begin
            du_ldx = 1'b1;
            du_ldy = 1'b1;
            du_ldz = 1'b1;
         end
         YDIV3: begin
            du_ldy = 1'b1;
            du_q   = 1'b1;
            du_r   = 1'b1;
         end
         YDIVZ: begin
            du_ldy = 1'b1;
            du_q   = 1'b1;
         end
         XUPD: begin
            du_ldx = 1'b1;
            du_p   = 1'b1;
         end
         RESP:    res_valid = 1'b1;
         default: busy = 1'b1;
      endcase
      res_data = res_valid ? du_x : '0;
   end

   // Operands stay on xin/yin even in IDLE so DU z never sees stray data.
   assign du_xin = op_x;
   assign du_yin = op_y;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_x       <= '0;
         op_y       <= '0;
         res_id     <= 1'b0;
         res_err    <= 1'b0;
         last_grant <= 1'b1;
         jobs_done  <= 8'd0;
      end else begin
         if (take) begin
            op_x       <= sel_x;
            op_y       <= sel_y;
            res_id     <= win;
            res_err    <= (sel_x == '0);
            last_grant <= win;
         end
         if (state == RESP && res_ready)
            jobs_done <= jobs_done + 8'd1;
      end
   end

endmodule

// File: tb/tb_du_job_scheduler.sv
// Scoreboard bench for du_job_scheduler with a behavioural DU model.
// Second instance with fixed priority checks grant order only.
module tb_du_job_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] req_valid;
   logic [7:0] req_x, req_y;
   logic [1:0] req_ready;
   logic       du_ldx, du_ldy, du_ldz, du_p, du_q, du_r;
   logic [3:0] du_xin, du_yin;
   logic [7:0] du_x;
   logic       res_valid, res_ready;
   logic [7:0] res_data;
   logic       res_id, res_err, busy;
   logic [7:0] jobs_done;

   logic [1:0] fp_rv;
   logic [1:0] fp_ready;
   logic       fp_ldx, fp_ldy, fp_ldz, fp_p, fp_q, fp_r;
   logic [3:0] fp_xin, fp_yin;
   logic       fp_rvld, fp_id, fp_err, fp_busy;
   logic [7:0] fp_data, fp_done;

   int n_tot  = 0;
   int n_pass = 0;
   int exp_done = 0;
   int fp_g0 = 0;
   int fp_g1 = 0;
   logic [9:0] sb[$];

   always #5 clk = ~clk;

   du_job_scheduler #(.XW(4), .RW(8), .RR_EN(1)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
      .req_ready(req_ready),
      .du_ldx(du_ldx), .du_ldy(du_ldy), .du_ldz(du_ldz),
      .du_p(du_p), .du_q(du_q), .du_r(du_r),
      .du_xin(du_xin), .du_yin(du_yin), .du_x(du_x),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_id(res_id), .res_err(res_err),
      .busy(busy), .jobs_done(jobs_done)
   );

   du_job_scheduler #(.XW(4), .RW(8), .RR_EN(0)) dut_fp (
      .clk(clk), .rst(rst),
      .req_valid(fp_rv), .req_x(req_x), .req_y(req_y),
      .req_ready(fp_ready),
      .du_ldx(fp_ldx), .du_ldy(fp_ldy), .du_ldz(fp_ldz),
      .du_p(fp_p), .du_q(fp_q), .du_r(fp_r),
      .du_xin(fp_xin), .du_yin(fp_yin), .du_x(8'd0),
      .res_valid(fp_rvld), .res_ready(1'b1),
      .res_data(fp_data), .res_id(fp_id), .res_err(fp_err),
      .busy(fp_busy), .jobs_done(fp_done)
   );

   // Behavioural DU: x/y/z registers steered by the control lines.
   logic [7:0] dx, dy, dz, xupd;
   assign du_x = dx;
   always_comb xupd = 8'(({1'b0, dx, 1'b0}) / 10'd3) - dy;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         dx <= 8'd0;
         dy <= 8'd0;
         dz <= 8'd0;
      end else begin
         if (du_ldz) dz <= {4'd0, du_xin} * {4'd0, du_xin};
         if (du_ldx) dx <= du_p ? xupd : {4'd0, du_xin};
         if (du_ldy) begin
            if (!du_q)     dy <= {4'd0, du_yin};
            else if (du_r) dy <= dy / 8'd3;
            else           dy <= (dz == 8'd0) ? 8'd0 : dy / dz;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   // Monitor: pops the scoreboard on every accepted response.
   initial begin : monitor
      logic [9:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (res_valid && res_ready) begin
            if (sb.size() == 0) begin
               chk("sb_unexpected_resp", 32'(1), 32'(0));
            end else begin
               e = sb.pop_front();
               chk("res_id", 32'(res_id), 32'(e[9]));
               chk("res_err", 32'(res_err), 32'(e[8]));
               if (!e[8]) chk("res_data", 32'(res_data), 32'(e[7:0]));
            end
            exp_done++;
         end
      end
   end

   initial begin : fp_mon
      forever begin
         @(negedge clk);
         #2;
         if (fp_ready[0]) fp_g0++;
         if (fp_ready[1]) fp_g1++;
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic wait_grant(output int g);
      g = -1;
      for (int n = 0; n < 40; n++) begin
         #1;
         if (req_ready != 2'b00) begin
            g = req_ready[1] ? 1 : 0;
            break;
         end
         @(negedge clk);
      end
      if (g < 0) chk("grant_timeout", 32'(0), 32'(1));
   endtask

   task automatic issue(input int id, input logic [3:0] x, y,
                        input logic [7:0] d, input logic e);
      int g;
      int n;
      req_x[id*4 +: 4] = x;
      req_y[id*4 +: 4] = y;
      req_valid[id]    = 1'b1;
      wait_grant(g);
      chk("grant_id", 32'(g), 32'(id));
      chk("req_ready_onehot", 32'(req_ready), 32'(2'b01 << id));
      sb.push_back({id[0], e, d});
      @(negedge clk);
      req_valid[id] = 1'b0;
      n = 1;
      while (!res_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("latency", 32'(n), 32'(5));
   endtask

   task automatic drain(input string nm);
      for (int n = 0; n < 40 && sb.size() != 0; n++) @(negedge clk);
      @(negedge clk);
      #3;
      chk({nm, "_sb_empty"}, 32'(sb.size()), 32'(0));
      chk({nm, "_jobs_done"}, 32'(jobs_done), 32'(exp_done));
   endtask

   initial begin : stim
      int g;
      int seen;
      rst       = 1'b1;
      req_valid = 2'b00;
      fp_rv     = 2'b00;
      req_x     = 8'd0;
      req_y     = 8'd0;
      res_ready = 1'b1;
      #3;
      chk("reset_outs",
          32'({req_ready, du_ldx, du_ldy, du_ldz, du_p, du_q, du_r,
               du_xin, du_yin, res_valid, res_data, res_id, res_err,
               busy, jobs_done}), 32'(0));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Basic jobs, hand-computed DU results
      issue(0, 4'd4, 4'd9, 8'd2, 1'b0);
      issue(1, 4'd2, 4'd12, 8'd0, 1'b0);
      issue(0, 4'd1, 4'd15, 8'd251, 1'b0);
      issue(0, 4'd15, 4'd15, 8'd10, 1'b0);
      drain("basic");

      // Back-pressure: result held, competing request not served
      res_ready = 1'b0;
      issue(0, 4'd4, 4'd9, 8'd2, 1'b0);
      req_x[7:4]   = 4'd2;
      req_y[7:4]   = 4'd12;
      req_valid[1] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("bp_hold", 32'({res_valid, res_data, res_id, req_ready, busy}),
             32'({1'b1, 8'd2, 1'b0, 2'b00, 1'b1}));
         chk("bp_jobs_done", 32'(jobs_done), 32'(exp_done));
         @(negedge clk);
      end
      res_ready = 1'b1;
      issue(1, 4'd2, 4'd12, 8'd0, 1'b0);
      drain("bp");

      // Arbitration: both requesters valid continuously
      rst = 1'b1;
      exp_done = 0;
      @(negedge clk);
      rst   = 1'b0;
      fp_g0 = 0;
      fp_g1 = 0;
      req_x = {4'd2, 4'd4};
      req_y = {4'd12, 4'd9};
      req_valid = 2'b11;
      fp_rv     = 2'b11;
      for (int i = 0; i < 4; i++) begin
         wait_grant(g);
         chk("rr_grant", 32'(g), 32'(i % 2));
         if (g == 1) sb.push_back({1'b1, 1'b0, 8'd0});
         else        sb.push_back({1'b0, 1'b0, 8'd2});
         @(negedge clk);
      end
      req_valid = 2'b00;
      fp_rv     = 2'b00;
      drain("rr");
      chk("fp_grants_req0", 32'(fp_g0), 32'(4));
      chk("fp_grants_req1", 32'(fp_g1), 32'(0));

      // Zero operand flags an error but still completes
      issue(0, 4'd0, 4'd5, 8'd0, 1'b1);
      drain("err");

      // Reset in the middle of a job drops it
      req_x[3:0]   = 4'd4;
      req_y[3:0]   = 4'd9;
      req_valid[0] = 1'b1;
      wait_grant(g);
      chk("midrst_grant", 32'(g), 32'(0));
      @(negedge clk);
      req_valid[0] = 1'b0;
      @(negedge clk);
      chk("ydiv3_ctrl", 32'({du_ldx, du_ldy, du_ldz, du_p, du_q, du_r}),
          32'(6'b010011));
      #1;
      rst = 1'b1;
      exp_done = 0;
      #1;
      chk("midrst_outs",
          32'({busy, res_valid, req_ready, du_ldx, du_ldy, du_ldz,
               du_p, du_q, du_r, du_xin, jobs_done}), 32'(0));
      @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (res_valid) seen = 1;
      end
      chk("midrst_no_resp", 32'(seen), 32'(0));
      chk("midrst_sb", 32'(sb.size()), 32'(0));

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
